// File: rtl/filtered_sample_packet_scheduler_pkg.sv
// rtl/filtered_sample_packet_scheduler_pkg.sv - shared constants and types for the sample packet scheduler
//
// Purpose: frame constants (sync word, header length, stream word width)
//          and the reader FSM state encoding. Imported by the interface, the
//          ping-pong buffer and the scheduler top.
// Ports:   none (package)

package filtered_sample_packet_scheduler_pkg;

  // Default width of a stream word
  localparam int TX_W = 16;

  // First word of every frame
  localparam logic [15:0] SYNC_WORD = 16'hA55A;

  // Words sent ahead of the samples: sync word, then sequence number
  localparam int HDR_LEN = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    SEQ  = 2'd2,
    DATA = 2'd3
  } rd_state_t;

endpackage

// File: rtl/filtered_sample_packet_scheduler_if.sv
// rtl/filtered_sample_packet_scheduler_if.sv - valid/ready framed stream toward the Ethernet packetiser
//
// Purpose: groups the outgoing stream signals.
// Signals: tx_data  - stream word
//          tx_valid - tx_data valid
//          tx_ready - sink accepts the word when tx_valid && tx_ready
//          tx_last  - final word of the frame
// Modports: master - scheduler (drives data/valid/last, samples ready)
//           slave  - packetiser (drives ready)

interface filtered_sample_packet_scheduler_if
  import filtered_sample_packet_scheduler_pkg::*;
#(
  parameter int DATA_W = TX_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/filtered_sample_packet_scheduler_buffer.sv
// rtl/filtered_sample_packet_scheduler_buffer.sv - two-bank ping-pong sample store with per-bank full flags
//
// Purpose: holds two banks of DEPTH samples. The writer fills one bank while
//          the reader drains the other. A bank is marked full by the write of
//          its last sample and marked empty when the reader releases it.
// Ports:   clk, rst            - clock, synchronous active-high reset
//          wr_en/wr_bank/wr_addr/wr_data - sample write port
//          set_full            - mark bank wr_bank full (with its last write)
//          clr_full/clr_bank   - mark bank clr_bank empty
//          rd_bank/rd_addr     - combinational read address
//          rd_data             - sample at rd_bank/rd_addr
//          full                - per-bank full flags

module pingpong_sample_buffer #(
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_bank,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                set_full,
  input  logic                clr_full,
  input  logic                clr_bank,
  input  logic                rd_bank,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic [1:0]          full
);

  logic [SAMPLE_W-1:0] mem [2][DEPTH];

  // Sample storage needs no reset: a bank is only read after being fully written
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Set is applied after clear so a same-cycle release/fill of one bank
  // leaves it full; in practice the set lands on the last write of a bank,
  // never on the first write that can follow a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (clr_full) begin
        full[clr_bank] <= 1'b0;
      end
      if (set_full) begin
        full[wr_bank] <= 1'b1;
      end
    end
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/filtered_sample_packet_scheduler.sv
// rtl/filtered_sample_packet_scheduler.sv - packs filtered samples into framed packets via ping-pong banks
//
// Purpose: collects signed FIR samples into SAMPLES_PER_PKT-sample banks and
//          streams each full bank as: sync word, sequence number, samples.
//          Samples arriving while the target bank is still full are dropped
//          and counted.
// Ports:   clk          - system clock, rising edge
//          rst          - synchronous active-high reset
//          enable       - 1 accepts samples; 0 ignores them and discards a partial bank
//          sample_in    - signed filtered sample
//          sample_valid - sample_in valid this cycle (no backpressure)
//          tx           - framed output stream (master modport)
//          overflow     - one-cycle pulse per dropped sample
//          drop_count   - saturating count of dropped samples
//          busy         - reader is sending a frame

module filtered_sample_packet_scheduler
  import filtered_sample_packet_scheduler_pkg::*;
#(
  parameter int SAMPLE_W        = 16,
  parameter int SAMPLES_PER_PKT = 64,
  parameter int DROP_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  filtered_sample_packet_scheduler_if.master tx,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  output logic                       busy
);

  localparam int IDX_W = $clog2(SAMPLES_PER_PKT);
  localparam int WC_W  = $clog2(SAMPLES_PER_PKT + HDR_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_PKT - 1);
  // Index of the final word of a frame (header words count from 0)
  localparam logic [WC_W-1:0]  LAST_WC  = WC_W'(SAMPLES_PER_PKT + HDR_LEN - 1);

  // Write side
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             take;
  logic             bank_avail;
  logic             accept;
  logic             drop;
  logic             wr_last;

  // Buffer
  logic [1:0]          full;
  logic [IDX_W-1:0]    rd_addr;
  logic [SAMPLE_W-1:0] rd_data;

  // Reader
  rd_state_t           state, state_n;
  logic [WC_W-1:0]     wcnt, wcnt_n;
  logic [WC_W-1:0]     nw;
  logic [15:0]         seq, seq_n;
  logic                rd_bank, rd_bank_n;
  logic [SAMPLE_W-1:0] data_q, data_n;
  logic                valid_q, valid_n;
  logic                last_q, last_n;
  logic                rd_release;
  logic                hs;

  pingpong_sample_buffer #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (SAMPLES_PER_PKT)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_idx),
    .wr_data  (sample_in),
    .set_full (accept && wr_last),
    .clr_full (rd_release),
    .clr_bank (rd_bank),
    .rd_bank  (rd_bank),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .full     (full)
  );

  // ---------------------------------------------------------------- writer
  assign take    = sample_valid && enable;
  // A bank being released this cycle counts as free, so a sample landing on
  // the release cycle is kept rather than dropped.
  assign bank_avail = !full[wr_bank] || (rd_release && (rd_bank == wr_bank));
  assign accept  = take && bank_avail;
  assign drop    = take && !bank_avail;
  assign wr_last = (wr_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= drop;
      if (drop && (drop_count != {DROP_W{1'b1}})) begin
        drop_count <= drop_count + DROP_W'(1);
      end
      if (!enable) begin
        // Abandon any partially filled bank; completed banks stay queued
        wr_idx <= '0;
      end else if (accept) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- reader
  assign hs = valid_q && tx.tx_ready;
  assign nw = wcnt + WC_W'(1);
  // Sample index of the word about to be loaded (only meaningful from SEQ on)
  assign rd_addr = IDX_W'(nw - WC_W'(HDR_LEN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      seq     <= '0;
      rd_bank <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      seq     <= seq_n;
      rd_bank <= rd_bank_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      last_q  <= last_n;
    end
  end

  always_comb begin
    state_n    = state;
    wcnt_n     = wcnt;
    seq_n      = seq;
    rd_bank_n  = rd_bank;
    data_n     = data_q;
    valid_n    = valid_q;
    last_n     = last_q;
    rd_release = 1'b0;

    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_n = SYNC;
          wcnt_n  = '0;
          data_n  = SAMPLE_W'(SYNC_WORD);
          valid_n = 1'b1;
          last_n  = 1'b0;
        end
      end

      SYNC, SEQ, DATA: begin
        if (hs) begin
          if (wcnt == LAST_WC) begin
            rd_release = 1'b1;
            seq_n      = seq + 16'd1;
            rd_bank_n  = ~rd_bank;
            wcnt_n     = '0;
            last_n     = 1'b0;
            // Chain straight into the next frame when the other bank is waiting
            if (full[~rd_bank]) begin
              state_n = SYNC;
              data_n  = SAMPLE_W'(SYNC_WORD);
              valid_n = 1'b1;
            end else begin
              state_n = IDLE;
              data_n  = '0;
              valid_n = 1'b0;
            end
          end else begin
            wcnt_n = nw;
            last_n = (nw == LAST_WC);
            if (state == SYNC) begin
              state_n = SEQ;
              data_n  = SAMPLE_W'(seq);
            end else begin
              state_n = DATA;
              data_n  = rd_data;
            end
          end
        end
      end

      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign tx.tx_last  = last_q;
  assign busy        = (state != IDLE);

endmodule
